pwm_core: RTL and testbench
===========================

PWM_CORE -- requirements
Module: pwm_core

Interface
REQ-001 Parameter WIDTH, default 16, is the width of the counter, prescaler and all compare/period values.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  run enable from the PWM register block.
REQ-005 mode  input  1  0 = edge-aligned (up-count), 1 = center-aligned (up/down).
REQ-006 period  input  WIDTH  counter top value (ARR).
REQ-007 duty1  input  WIDTH  channel-1 compare value (CCR1).
REQ-008 duty2  input  WIDTH  channel-2 compare value (CCR2).
REQ-009 prescaler_div  input  WIDTH  tick divider; tick rate = clk/(prescaler_div+1).
REQ-010 pwm_out1  output  1  channel-1 PWM.
REQ-011 pwm_out2  output  1  channel-2 PWM.
REQ-012 cnt  output  WIDTH  current main counter value.
REQ-013 dir  output  1  0 = counting up, 1 = counting down.
REQ-014 update_evt  output  1  one-clock pulse on each shadow-reload event.

Function
REQ-015 Two states SHALL exist: IDLE and RUN.
REQ-016 IDLE: psc counter = 0, cnt = 0, dir = 0, pwm_out1/2 = 0, update_evt = 0.
REQ-017 IDLE->RUN on the first clock with en=1: shadows period_sh, duty1_sh, duty2_sh, psc_sh, mode_sh SHALL load from the inputs; cnt = 0; psc counter = 0; update_evt SHALL NOT pulse.
REQ-018 RUN->IDLE on the first clock with en=0, regardless of counter position; all IDLE values SHALL hold from that edge.
REQ-019 Prescaler: in RUN, psc counter increments each clk; when psc counter == psc_sh it SHALL wrap to 0 and assert the internal tick for that cycle.
REQ-020 The main counter SHALL advance only on cycles where tick is asserted.
REQ-021 Edge mode (mode_sh=0): on tick, cnt < period_sh -> cnt+1; cnt == period_sh -> cnt = 0, update event.
REQ-022 Center mode (mode_sh=1): on tick with dir=0, cnt < period_sh -> cnt+1, else dir = 1, cnt-1; with dir=1, cnt > 0 -> cnt-1, else dir = 0, cnt+1, update event.
REQ-023 period_sh == 0: cnt SHALL stay 0 and an update event SHALL occur on every tick, in both modes; dir stays 0.
REQ-024 Update event: shadows SHALL reload from the current inputs on that same edge; update_evt SHALL be 1 for exactly that following clock cycle.
REQ-025 Input changes during RUN SHALL affect the counter and outputs only after the next update event.
REQ-026 pwm_out1 = RUN & (cnt < duty1_sh); pwm_out2 = RUN & (cnt < duty2_sh); unsigned compare; both are combinational from registered state, so glitch-free per clock.
REQ-027 duty == 0 SHALL give a constant 0; duty > period_sh SHALL give a constant 1 in RUN.
REQ-028 Edge-mode output period = (period_sh+1)*(psc_sh+1) clocks; center-mode period = 2*period_sh*(psc_sh+1) clocks for period_sh > 0.
REQ-029 All counter arithmetic SHALL be WIDTH-bit with no overflow, because cnt never exceeds period_sh.

Reset
REQ-030 rst_n low SHALL force IDLE and all outputs and shadows to 0 immediately, regardless of clk.
REQ-031 Deassertion of rst_n with en=1 SHALL enter RUN on the first clock edge after release, per REQ-017.

Verification
REQ-032 Edge mode: period=4, duty1=2, div=0, en=1 -> cnt cycles 0..4, pwm_out1 high 2 of every 5 clocks, update_evt every 5 clocks.
REQ-033 Prescaler: period=3, div=2 -> cnt advances every 3rd clock, output period 12 clocks, update_evt once per 12 clocks.
REQ-034 Center mode: period=4, duty2=2, div=0 -> cnt 0,1,2,3,4,3,2,1,0,1,...; dir flips at 4 and at 0; pwm_out2 high while cnt<2; update_evt at each return to 0 (every 8 clocks).
REQ-035 Shadowing: change duty1 2->4 mid-period -> old duty holds until the update_evt, new duty applies from the next period; change period 4->9 -> wrap still at 4 once, then at 9.
REQ-036 Boundaries: duty1=0 -> pwm_out1 constant 0; duty1=7 with period=4 -> constant 1; period=0 -> cnt stays 0 with update_evt every tick.
REQ-037 Abort/reset: drop en at cnt=3 -> next edge cnt=0 and outputs 0; assert rst_n low mid-count -> outputs 0 asynchronously; re-enable -> restart from cnt=0 with freshly loaded shadows.

Source files
------------

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - two-channel PWM timer with prescaler, edge/center modes and shadowed settings
module pwm_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty1,
    input  logic [WIDTH-1:0] duty2,
    input  logic [WIDTH-1:0] prescaler_div,
    output logic             pwm_out1,
    output logic             pwm_out2,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             update_evt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] psc_cnt;
    logic [WIDTH-1:0] period_sh;
    logic [WIDTH-1:0] duty1_sh;
    logic [WIDTH-1:0] duty2_sh;
    logic [WIDTH-1:0] psc_sh;
    logic             mode_sh;

    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] cnt_nxt;
    logic             dir_nxt;

    assign tick = (state == RUN) && (psc_cnt == psc_sh);

    // Next counter position for a tick; wrap marks the shadow-reload point of the period.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        wrap    = 1'b0;
        if (period_sh == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
            wrap    = 1'b1;
        end else if (!mode_sh) begin
            dir_nxt = 1'b0;
            if (cnt < period_sh) begin
                cnt_nxt = cnt + WIDTH'(1);
            end else begin
                cnt_nxt = '0;
                wrap    = 1'b1;
            end
        end else if (!dir) begin
            if (cnt < period_sh) begin
                cnt_nxt = cnt + WIDTH'(1);
            end else begin
                dir_nxt = 1'b1;
                cnt_nxt = cnt - WIDTH'(1);
            end
        end else begin
            if (cnt != '0) begin
                cnt_nxt = cnt - WIDTH'(1);
            end else begin
                dir_nxt = 1'b0;
                cnt_nxt = cnt + WIDTH'(1);
                wrap    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            psc_cnt    <= '0;
            cnt        <= '0;
            dir        <= 1'b0;
            update_evt <= 1'b0;
            period_sh  <= '0;
            duty1_sh   <= '0;
            duty2_sh   <= '0;
            psc_sh     <= '0;
            mode_sh    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    psc_cnt    <= '0;
                    cnt        <= '0;
                    dir        <= 1'b0;
                    update_evt <= 1'b0;
                    if (en) begin
                        state     <= RUN;
                        period_sh <= period;
                        duty1_sh  <= duty1;
                        duty2_sh  <= duty2;
                        psc_sh    <= prescaler_div;
                        mode_sh   <= mode;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state      <= IDLE;
                        psc_cnt    <= '0;
                        cnt        <= '0;
                        dir        <= 1'b0;
                        update_evt <= 1'b0;
                    end else begin
                        psc_cnt    <= tick ? '0 : psc_cnt + WIDTH'(1);
                        update_evt <= tick & wrap;
                        if (tick) begin
                            cnt <= cnt_nxt;
                            dir <= dir_nxt;
                            // Settings written mid-period only take effect from here on.
                            if (wrap) begin
                                period_sh <= period;
                                duty1_sh  <= duty1;
                                duty2_sh  <= duty2;
                                psc_sh    <= prescaler_div;
                                mode_sh   <= mode;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pwm_out1 = (state == RUN) && (cnt < duty1_sh);
    assign pwm_out2 = (state == RUN) && (cnt < duty2_sh);

endmodule

// File: tb/tb_pwm_core.sv
// tb/tb_pwm_core.sv - directed self-checking bench for pwm_core
module tb_pwm_core;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [15:0] period;
    logic [15:0] duty1;
    logic [15:0] duty2;
    logic [15:0] prescaler_div;
    logic        pwm_out1;
    logic        pwm_out2;
    logic [15:0] cnt;
    logic        dir;
    logic        update_evt;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_core #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .period       (period),
        .duty1        (duty1),
        .duty2        (duty2),
        .prescaler_div(prescaler_div),
        .pwm_out1     (pwm_out1),
        .pwm_out2     (pwm_out2),
        .cnt          (cnt),
        .dir          (dir),
        .update_evt   (update_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench at the falling edge right after the IDLE->RUN edge.
    task automatic start(input logic [15:0] p, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [15:0] dv, input logic m);
        en = 1'b0;
        step();
        period = p; duty1 = d1; duty2 = d2; prescaler_div = dv; mode = m;
        en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (cnt !== 16'd0 || dir !== 1'b0 || pwm_out1 !== 1'b0 || pwm_out2 !== 1'b0 || update_evt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state cnt=%0d dir=%b p1=%b p2=%b upd=%b required all 0",
                     cnt, dir, pwm_out1, pwm_out2, update_evt);
        end
        en = 1'b1; period = 16'd4; duty1 = 16'd2; duty2 = 16'd2;
        repeat (3) step();
        n_tests++;
        if (cnt !== 16'd0 || pwm_out1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held cnt=%0d p1=%b required 0 0", cnt, pwm_out1);
        end
        en = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_edge();
        logic [15:0] ec;
        start(16'd4, 16'd2, 16'd5, 16'd0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            ec = 16'(k % 5);
            n_tests++;
            if (cnt !== ec) begin
                n_fail++;
                $display("FAIL edge_cnt k=%0d got %0d required %0d", k, cnt, ec);
            end
            n_tests++;
            if (pwm_out1 !== (ec < 2) || pwm_out2 !== 1'b1) begin
                n_fail++;
                $display("FAIL edge_pwm k=%0d got %b/%b required %b/1", k, pwm_out1, pwm_out2, ec < 2);
            end
            n_tests++;
            if (update_evt !== (k > 0 && k % 5 == 0) || dir !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_upd k=%0d got upd=%b dir=%b required %b 0", k, update_evt, dir, (k > 0 && k % 5 == 0));
            end
            step();
        end
    endtask

    task automatic test_prescaler();
        logic [15:0] ec;
        start(16'd3, 16'd2, 16'd0, 16'd2, 1'b0);
        for (int k = 0; k < 26; k++) begin
            ec = 16'((k / 3) % 4);
            n_tests++;
            if (cnt !== ec || pwm_out1 !== (ec < 2) || pwm_out2 !== 1'b0) begin
                n_fail++;
                $display("FAIL psc_cnt k=%0d got %0d/%b/%b required %0d/%b/0", k, cnt, pwm_out1, pwm_out2, ec, ec < 2);
            end
            n_tests++;
            if (update_evt !== (k > 0 && k % 12 == 0)) begin
                n_fail++;
                $display("FAIL psc_upd k=%0d got %b required %b", k, update_evt, (k > 0 && k % 12 == 0));
            end
            step();
        end
    endtask

    task automatic test_center();
        logic [15:0] pat [8];
        logic [15:0] ec;
        logic        ed;
        pat = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1};
        start(16'd4, 16'd0, 16'd2, 16'd0, 1'b1);
        for (int k = 0; k < 21; k++) begin
            ec = pat[k % 8];
            ed = (k > 0) && (k % 8 == 5 || k % 8 == 6 || k % 8 == 7 || k % 8 == 0);
            n_tests++;
            if (cnt !== ec || dir !== ed) begin
                n_fail++;
                $display("FAIL center_cnt k=%0d got %0d dir=%b required %0d dir=%b", k, cnt, dir, ec, ed);
            end
            n_tests++;
            if (pwm_out2 !== (ec < 2) || pwm_out1 !== 1'b0) begin
                n_fail++;
                $display("FAIL center_pwm k=%0d got %b/%b required 0/%b", k, pwm_out1, pwm_out2, ec < 2);
            end
            n_tests++;
            if (update_evt !== (k > 1 && k % 8 == 1)) begin
                n_fail++;
                $display("FAIL center_upd k=%0d got %b required %b", k, update_evt, (k > 1 && k % 8 == 1));
            end
            step();
        end
    endtask

    task automatic test_shadow();
        logic [15:0] ec;
        logic [15:0] ed;
        start(16'd4, 16'd2, 16'd0, 16'd0, 1'b0);
        for (int k = 0; k < 22; k++) begin
            ec = (k < 10) ? 16'(k % 5) : 16'((k - 10) % 10);
            ed = (k < 5) ? 16'd2 : 16'd4;
            n_tests++;
            if (cnt !== ec || pwm_out1 !== (ec < ed)) begin
                n_fail++;
                $display("FAIL shadow k=%0d got cnt=%0d p1=%b required cnt=%0d p1=%b", k, cnt, pwm_out1, ec, ec < ed);
            end
            n_tests++;
            if (update_evt !== (k == 5 || k == 10 || k == 20)) begin
                n_fail++;
                $display("FAIL shadow_upd k=%0d got %b required %b", k, update_evt, (k == 5 || k == 10 || k == 20));
            end
            if (k == 2) duty1 = 16'd4;
            if (k == 6) period = 16'd9;
            step();
        end
    endtask

    task automatic test_boundary();
        start(16'd4, 16'd0, 16'd7, 16'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (pwm_out1 !== 1'b0 || pwm_out2 !== 1'b1) begin
                n_fail++;
                $display("FAIL duty_limits k=%0d got %b/%b required 0/1", k, pwm_out1, pwm_out2);
            end
            step();
        end
        for (int m = 0; m < 2; m++) begin
            start(16'd0, 16'd1, 16'd0, 16'd0, m[0]);
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (cnt !== 16'd0 || dir !== 1'b0 || update_evt !== (k > 0) || pwm_out1 !== 1'b1 || pwm_out2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL period0 mode=%0d k=%0d got cnt=%0d dir=%b upd=%b p=%b%b required 0 0 %b 10",
                             m, k, cnt, dir, update_evt, pwm_out1, pwm_out2, (k > 0));
                end
                step();
            end
        end
    endtask

    task automatic test_abort();
        start(16'd4, 16'd4, 16'd4, 16'd0, 1'b0);
        repeat (3) step();
        n_tests++;
        if (cnt !== 16'd3 || pwm_out1 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre got cnt=%0d p1=%b required 3 1", cnt, pwm_out1);
        end
        en = 1'b0;
        step();
        n_tests++;
        if (cnt !== 16'd0 || pwm_out1 !== 1'b0 || pwm_out2 !== 1'b0 || update_evt !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_en got cnt=%0d p=%b%b upd=%b required 0 00 0", cnt, pwm_out1, pwm_out2, update_evt);
        end

        start(16'd4, 16'd3, 16'd3, 16'd0, 1'b1);
        repeat (6) step();
        n_tests++;
        if (cnt !== 16'd2 || dir !== 1'b1 || pwm_out1 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rst_pre got cnt=%0d dir=%b p1=%b required 2 1 1", cnt, dir, pwm_out1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cnt !== 16'd0 || dir !== 1'b0 || pwm_out1 !== 1'b0 || pwm_out2 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got cnt=%0d dir=%b p=%b%b required 0 0 00", cnt, dir, pwm_out1, pwm_out2);
        end
        period = 16'd2; duty1 = 16'd1; duty2 = 16'd0; mode = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (cnt !== 16'(k % 3) || pwm_out1 !== (k % 3 == 0) || update_evt !== (k == 3)) begin
                n_fail++;
                $display("FAIL restart k=%0d got cnt=%0d p1=%b upd=%b required %0d %b %b",
                         k, cnt, pwm_out1, update_evt, k % 3, (k % 3 == 0), (k == 3));
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0;
        period = '0; duty1 = '0; duty2 = '0; prescaler_div = '0;
        test_reset();
        test_edge();
        test_prescaler();
        test_center();
        test_shadow();
        test_boundary();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
